// File: rtl/dbus_demux_if.sv
// Bundle of host-side and slave-side signals around the data-bus demultiplexer.
// The slave modport is the demux view; master is the environment driving it.
interface dbus_demux_if #(
    parameter int NUM_SLAVES = 2
) ();
    logic                       data_req_i;
    logic                       data_gnt_o;
    logic                       data_rvalid_o;
    logic                       data_we_i;
    logic [3:0]                 data_be_i;
    logic [31:0]                data_addr_i;
    logic [31:0]                data_wdata_i;
    logic [31:0]                data_rdata_o;
    logic                       data_err_o;
    logic [NUM_SLAVES-1:0]      s_req_o;
    logic [NUM_SLAVES-1:0]      s_gnt_i;
    logic [NUM_SLAVES-1:0]      s_rvalid_i;
    logic                       s_we_o;
    logic [3:0]                 s_be_o;
    logic [31:0]                s_addr_o;
    logic [31:0]                s_wdata_o;
    logic [NUM_SLAVES*32-1:0]   s_rdata_i;
    logic [NUM_SLAVES-1:0]      s_err_i;
    logic                       err_flag_o;
    logic [31:0]                err_addr_o;

    modport slave (
        input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        input  s_gnt_i, s_rvalid_i, s_rdata_i, s_err_i,
        output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
        output s_req_o, s_we_o, s_be_o, s_addr_o, s_wdata_o,
        output err_flag_o, err_addr_o
    );

    modport master (
        output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        output s_gnt_i, s_rvalid_i, s_rdata_i, s_err_i,
        input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
        input  s_req_o, s_we_o, s_be_o, s_addr_o, s_wdata_o,
        input  err_flag_o, err_addr_o
    );
endinterface

// File: rtl/dbus_demux.sv
// Data-bus demultiplexer: address decode to N slaves, in-order pipelined responses,
// internal bus-error responder. Define DBUS_DEMUX_ERR_LOG_EN to capture the first miss.
module dbus_demux #(
    parameter int                       NUM_SLAVES      = 2,
    parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE      = {32'h0000_1000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK      = {32'hFFFF_F000, 32'hFFFF_F000},
    parameter int                       MAX_OUTSTANDING = 2
) (
    input  logic          clk,
    input  logic          rst,
    dbus_demux_if.slave   bus
);
    localparam int TGT_W = $clog2(NUM_SLAVES + 1);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [TGT_W-1:0] ERR_TGT = TGT_W'(NUM_SLAVES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [TGT_W-1:0]      cur_tgt_q, cur_tgt_d;
    logic                  err_rvalid_q, err_rvalid_d;

    logic [TGT_W-1:0]      sel;
    logic                  can_issue, slv_gnt, gnt, hs;
    logic [NUM_SLAVES-1:0] s_req;
    logic                  slv_rvalid, slv_err, resp;
    logic [31:0]           slv_rdata;

    // Lowest-index hit wins; no hit routes to the error responder.
    always_comb begin
        sel = ERR_TGT;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((bus.data_addr_i & SLAVE_MASK[i*32 +: 32]) == SLAVE_BASE[i*32 +: 32])
                sel = TGT_W'(i);
        end
    end

    // Switching targets waits for a full drain so responses cannot reorder.
    always_comb begin
        can_issue = (cnt_q == '0) || ((sel == cur_tgt_q) && (cnt_q < CNT_MAX));
        slv_gnt   = 1'b0;
        s_req     = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel == TGT_W'(i)) begin
                slv_gnt  = bus.s_gnt_i[i];
                s_req[i] = bus.data_req_i && can_issue;
            end
        end
        gnt = can_issue && bus.data_req_i && ((sel == ERR_TGT) ? 1'b1 : slv_gnt);
        hs  = bus.data_req_i && gnt;
    end

    always_comb begin
        slv_rvalid = 1'b0;
        slv_rdata  = '0;
        slv_err    = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (cur_tgt_q == TGT_W'(i)) begin
                slv_rvalid = bus.s_rvalid_i[i];
                slv_rdata  = bus.s_rdata_i[i*32 +: 32];
                slv_err    = bus.s_err_i[i];
            end
        end
        resp = (cnt_q != '0) && ((cur_tgt_q == ERR_TGT) ? err_rvalid_q : slv_rvalid);
    end

    always_comb begin
        cnt_d = cnt_q;
        if (hs && !resp)
            cnt_d = cnt_q + CNT_W'(1);
        else if (!hs && resp)
            cnt_d = cnt_q - CNT_W'(1);
        cur_tgt_d    = hs ? sel : cur_tgt_q;
        err_rvalid_d = hs && (sel == ERR_TGT);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q        <= '0;
            cur_tgt_q    <= '0;
            err_rvalid_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            cur_tgt_q    <= cur_tgt_d;
            err_rvalid_q <= err_rvalid_d;
        end
    end

    assign bus.data_gnt_o    = gnt;
    assign bus.s_req_o       = s_req;
    assign bus.data_rvalid_o = resp;
    assign bus.data_rdata_o  = (resp && (cur_tgt_q != ERR_TGT)) ? slv_rdata : 32'h0;
    assign bus.data_err_o    = resp && ((cur_tgt_q == ERR_TGT) || slv_err);
    assign bus.s_we_o        = bus.data_we_i;
    assign bus.s_be_o        = bus.data_be_i;
    assign bus.s_addr_o      = bus.data_addr_i;
    assign bus.s_wdata_o     = bus.data_wdata_i;

`ifdef DBUS_DEMUX_ERR_LOG_EN
    logic        err_flag_q, err_flag_d;
    logic [31:0] err_addr_q, err_addr_d;

    // Only the first miss after reset is recorded.
    always_comb begin
        err_flag_d = err_flag_q;
        err_addr_d = err_addr_q;
        if (hs && (sel == ERR_TGT) && !err_flag_q) begin
            err_flag_d = 1'b1;
            err_addr_d = bus.data_addr_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            err_flag_q <= 1'b0;
            err_addr_q <= '0;
        end else begin
            err_flag_q <= err_flag_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign bus.err_flag_o = err_flag_q;
    assign bus.err_addr_o = err_addr_q;
`else
    assign bus.err_flag_o = 1'b0;
    assign bus.err_addr_o = 32'h0;
`endif
endmodule

// File: tb/tb_dbus_demux.sv
// Directed bench for dbus_demux: expected responses queued at issue, checked by a monitor.
module tb_dbus_demux;
    typedef struct {
        int          due;
        logic [31:0] d;
        logic        e;
    } rsp_t;

    typedef struct {
        logic [31:0] d;
        logic        e;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;

    rsp_t sq0[$];
    rsp_t sq1[$];
    exp_t sb[$];

    int          lat0 = 1;
    int          lat1 = 1;
    logic [31:0] slv_rd = '0;
    logic        slv_er = 1'b0;

    dbus_demux_if #(.NUM_SLAVES(2)) bus ();

    dbus_demux #(
        .NUM_SLAVES(2),
        .SLAVE_BASE({32'h0000_1000, 32'h0000_0000}),
        .SLAVE_MASK({32'hFFFF_F000, 32'hFFFF_F000}),
        .MAX_OUTSTANDING(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Slave model: capture handshakes on the rising edge.
    initial begin
        forever begin
            @(posedge clk);
            if (bus.s_req_o[0] && bus.s_gnt_i[0]) sq0.push_back('{cyc + lat0, slv_rd, slv_er});
            if (bus.s_req_o[1] && bus.s_gnt_i[1]) sq1.push_back('{cyc + lat1, slv_rd, slv_er});
            cyc++;
        end
    end

    // Slave model: present responses on the falling edge.
    initial begin
        bus.s_rvalid_i = '0;
        bus.s_rdata_i  = {32'hDEAD_0001, 32'hDEAD_0000};
        bus.s_err_i    = '0;
        forever begin
            @(negedge clk);
            bus.s_rvalid_i = '0;
            bus.s_rdata_i  = {32'hDEAD_0001, 32'hDEAD_0000};
            bus.s_err_i    = '0;
            if (sq0.size() > 0 && sq0[0].due == cyc) begin
                bus.s_rvalid_i[0]     = 1'b1;
                bus.s_rdata_i[31:0]   = sq0[0].d;
                bus.s_err_i[0]        = sq0[0].e;
                void'(sq0.pop_front());
            end
            if (sq1.size() > 0 && sq1[0].due == cyc) begin
                bus.s_rvalid_i[1]     = 1'b1;
                bus.s_rdata_i[63:32]  = sq1[0].d;
                bus.s_err_i[1]        = sq1[0].e;
                void'(sq1.pop_front());
            end
        end
    end

    // Monitor: every host response must match the head of the scoreboard.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            if (rst && bus.data_rvalid_o) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rvalid", 32'd1, 32'd0);
                end else begin
                    x = sb.pop_front();
                    chk("resp_rdata", bus.data_rdata_o, x.d);
                    chk("resp_err", {31'd0, bus.data_err_o}, {31'd0, x.e});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a falling edge; returns at the falling edge after the handshake.
    task automatic issue(input logic we, input logic [3:0] be, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rsp_d, input logic rsp_e,
                         input logic [31:0] exp_d, input logic exp_e,
                         input logic [1:0] exp_sreq, input int exp_waits);
        int waits;
        waits = 0;
        bus.data_req_i   = 1'b1;
        bus.data_we_i    = we;
        bus.data_be_i    = be;
        bus.data_addr_i  = addr;
        bus.data_wdata_i = wdata;
        slv_rd = rsp_d;
        slv_er = rsp_e;
        #1;
        while (!bus.data_gnt_o && waits < 20) begin
            chk("stall_sreq", {30'd0, bus.s_req_o}, 32'd0);
            @(negedge clk);
            #1;
            waits++;
        end
        if (!bus.data_gnt_o) begin
            chk("gnt_timeout", 32'd0, 32'd1);
        end else begin
            sb.push_back('{exp_d, exp_e});
            chk("sreq", {30'd0, bus.s_req_o}, {30'd0, exp_sreq});
            chk("bcast", {bus.s_addr_o ^ bus.s_wdata_o, 27'd0, bus.s_we_o, bus.s_be_o},
                         {addr ^ wdata, 27'd0, we, be});
        end
        chk("gnt_waits", waits, exp_waits);
        @(negedge clk);
        bus.data_req_i = 1'b0;
    endtask

    initial begin
        logic [31:0] log_addr;
        logic        log_flag;
        bus.data_req_i   = 1'b0;
        bus.data_we_i    = 1'b0;
        bus.data_be_i    = 4'hF;
        bus.data_addr_i  = '0;
        bus.data_wdata_i = '0;
        bus.s_gnt_i      = 2'b11;
`ifdef DBUS_DEMUX_ERR_LOG_EN
        log_flag = 1'b1;
        log_addr = 32'h8000_0000;
`else
        log_flag = 1'b0;
        log_addr = 32'h0;
`endif
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_gnt", {31'd0, bus.data_gnt_o}, 32'd0);
        chk("rst_sreq", {30'd0, bus.s_req_o}, 32'd0);
        chk("rst_rvalid", {31'd0, bus.data_rvalid_o}, 32'd0);
        chk("rst_flag", {31'd0, bus.err_flag_o}, 32'd0);
        chk("rst_addr", bus.err_addr_o, 32'd0);
        @(negedge clk);

        // Single read to slave 0
        lat0 = 1;
        issue(1'b0, 4'hF, 32'h0000_0004, 32'h0, 32'h1234_5678, 1'b0, 32'h1234_5678, 1'b0, 2'b01, 0);
        idle(3);

        // Partial write to slave 1
        lat1 = 1;
        issue(1'b1, 4'b0011, 32'h0000_1008, 32'hAABB_CCDD, 32'h0, 1'b0, 32'h0, 1'b0, 2'b10, 0);
        idle(3);

        // Three reads to slave 0, third blocked by the outstanding limit
        lat0 = 3;
        issue(1'b0, 4'hF, 32'h0000_0100, 32'h0, 32'h0000_0011, 1'b0, 32'h0000_0011, 1'b0, 2'b01, 0);
        issue(1'b0, 4'hF, 32'h0000_0104, 32'h0, 32'h0000_0022, 1'b0, 32'h0000_0022, 1'b0, 2'b01, 0);
        issue(1'b0, 4'hF, 32'h0000_0108, 32'h0, 32'h0000_0033, 1'b0, 32'h0000_0033, 1'b0, 2'b01, 2);
        idle(6);

        // Target switch stalls until slave 0 drains; slave 1 answers with an error
        lat0 = 2;
        lat1 = 1;
        issue(1'b0, 4'hF, 32'h0000_0010, 32'h0, 32'h5555_AAAA, 1'b0, 32'h5555_AAAA, 1'b0, 2'b01, 0);
        issue(1'b0, 4'hF, 32'h0000_1020, 32'h0, 32'hCAFE_0001, 1'b1, 32'hCAFE_0001, 1'b1, 2'b10, 2);
        idle(3);

        // Two unmapped reads answered by the error responder
        issue(1'b0, 4'hF, 32'h8000_0000, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 2'b00, 0);
        issue(1'b0, 4'hF, 32'h9000_0000, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 2'b00, 0);
        idle(2);
        chk("log_flag", {31'd0, bus.err_flag_o}, {31'd0, log_flag});
        chk("log_addr", bus.err_addr_o, log_addr);

        // Reset with two reads in flight; late slave responses must be dropped
        lat0 = 4;
        issue(1'b0, 4'hF, 32'h0000_0020, 32'h0, 32'h0BAD_0001, 1'b0, 32'h0BAD_0001, 1'b0, 2'b01, 0);
        issue(1'b0, 4'hF, 32'h0000_0024, 32'h0, 32'h0BAD_0002, 1'b0, 32'h0BAD_0002, 1'b0, 2'b01, 0);
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst2_rvalid", {31'd0, bus.data_rvalid_o}, 32'd0);
        chk("rst2_flag", {31'd0, bus.err_flag_o}, 32'd0);
        chk("rst2_addr", bus.err_addr_o, 32'd0);
        @(negedge clk);
        idle(4);
        lat1 = 1;
        issue(1'b0, 4'hF, 32'h0000_1000, 32'h0, 32'h7777_0000, 1'b0, 32'h7777_0000, 1'b0, 2'b10, 0);
        idle(4);
        chk("sb_drained", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
